clock_set_controller: RTL and testbench

//  Drives the i_up/i_down pulse inputs of the sec/min/hour wrap counters (mod-60, mod-24) of the clock.

---
 rtl/clock_set_controller_if.sv | 27 ++
 rtl/clock_set_controller.sv | 172 +++++++++++++++++
 tb/tb_clock_set_controller.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_controller_if.sv
// Button/tick inputs and counter-drive outputs of the clock set controller.
// The slave side belongs to the controller.
interface clock_set_controller_if;
  logic       i_tick;
  logic       i_btn_up;
  logic       i_btn_down;
  logic       i_btn_mode;
  logic       o_sec_up;
  logic       o_sec_down;
  logic       o_min_up;
  logic       o_min_down;
  logic       o_hour_up;
  logic       o_hour_down;
  logic [1:0] o_mode;

  modport master (
    output i_tick, i_btn_up, i_btn_down, i_btn_mode,
    input  o_sec_up, o_sec_down, o_min_up, o_min_down,
    input  o_hour_up, o_hour_down, o_mode
  );

  modport slave (
    input  i_tick, i_btn_up, i_btn_down, i_btn_mode,
    output o_sec_up, o_sec_down, o_min_up, o_min_down,
    output o_hour_up, o_hour_down, o_mode
  );
endinterface

// File: rtl/clock_set_controller.sv
// RUN/SET mode controller: debounces UP/DOWN/MODE, turns ticks and
// presses (with auto-repeat) into 1-cycle up/down pulses for the counters.
module clock_set_controller #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 500000,
  parameter int REPEAT_CYCLES   = 100000
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  clock_set_controller_if.slave  bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_e;

  logic [2:0]         raw;
  logic [2:0]         deb;
  logic [2:0]         deb_q;
  logic [2:0]         press;
  logic [2:0][DW-1:0] db_cnt;

  mode_e       state_q, state_d;
  logic        hold_q, hold_d;
  logic        hdn_q, hdn_d;
  logic        rep_q, rep_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [5:0]  pulse_q, pulse_d;
  logic        fu, fd;
  logic        held;
  logic        dual;

  // bit 0 = UP, bit 1 = DOWN, bit 2 = MODE
  assign raw = {bus.i_btn_mode, bus.i_btn_down, bus.i_btn_up};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      deb    <= '0;
      deb_q  <= '0;
      db_cnt <= '0;
    end else begin
      deb_q <= deb;
      for (int b = 0; b < 3; b++) begin
        if (raw[b] == deb[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[b]    <= raw[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + DW'(1);
        end
      end
    end
  end

  assign press = deb & ~deb_q;
  assign held  = hdn_q ? deb[1] : deb[0];
  // a press while the opposite button is held counts as a clear
  assign dual  = (press[0] & press[1]) |
                 (press[0] & deb[1]) |
                 (press[1] & deb[0]);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= RUN;
      hold_q  <= 1'b0;
      hdn_q   <= 1'b0;
      rep_q   <= 1'b0;
      hcnt_q  <= '0;
      rcnt_q  <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hdn_q   <= hdn_d;
      rep_q   <= rep_d;
      hcnt_q  <= hcnt_d;
      rcnt_q  <= rcnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    hdn_d   = hdn_q;
    rep_d   = rep_q;
    hcnt_d  = hcnt_q;
    rcnt_d  = rcnt_q;
    pulse_d = '0;
    fu      = 1'b0;
    fd      = 1'b0;

    if (state_q == RUN && bus.i_tick) pulse_d[5] = 1'b1;

    if (press[2]) begin
      unique case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        SET_SEC:  state_d = RUN;
      endcase
      hold_d = 1'b0;
      rep_d  = 1'b0;
      hcnt_d = '0;
      rcnt_d = '0;
    end else if (state_q != RUN) begin
      if (dual) begin
        fu     = 1'b1;
        fd     = 1'b1;
        hold_d = 1'b0;
        rep_d  = 1'b0;
        hcnt_d = '0;
        rcnt_d = '0;
      end else if (press[0] | press[1]) begin
        fu     = press[0];
        fd     = press[1];
        hold_d = 1'b1;
        hdn_d  = press[1];
        rep_d  = 1'b0;
        hcnt_d = '0;
        rcnt_d = '0;
      end else if (hold_q) begin
        if (!held) begin
          hold_d = 1'b0;
          rep_d  = 1'b0;
          hcnt_d = '0;
          rcnt_d = '0;
        end else if (!rep_q) begin
          if (hcnt_q == HW'(HOLD_CYCLES - 1)) begin
            rep_d  = 1'b1;
            rcnt_d = '0;
            fu     = ~hdn_q;
            fd     = hdn_q;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end else begin
          if (rcnt_q == RW'(REPEAT_CYCLES - 1)) begin
            rcnt_d = '0;
            fu     = ~hdn_q;
            fd     = hdn_q;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
    end

    unique case (state_q)
      RUN:      ;
      SET_HOUR: pulse_d[1:0] = {fu, fd};
      SET_MIN:  pulse_d[3:2] = {fu, fd};
      SET_SEC:  pulse_d[5:4] = {fu, fd};
    endcase
  end

  assign bus.o_sec_up    = pulse_q[5];
  assign bus.o_sec_down  = pulse_q[4];
  assign bus.o_min_up    = pulse_q[3];
  assign bus.o_min_down  = pulse_q[2];
  assign bus.o_hour_up   = pulse_q[1];
  assign bus.o_hour_down = pulse_q[0];
  assign bus.o_mode      = state_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: vector table, directed corner
// sequences and random stimulus against a cycle-level reference model.
module tb_clock_set_controller;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;

  clock_set_controller_if bus ();

  clock_set_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    bit       tick;
    bit       up;
    bit       dn;
    bit       md;
    bit [5:0] pulses;
    bit [1:0] mode;
  } vec_t;

  vec_t tbl [30];

  // reference model state
  bit       m_deb  [3];
  bit       m_debp [3];
  int       m_run  [3];
  int       m_mode;
  bit [5:0] m_out;
  bit       m_hact;
  int       m_hdir;
  int       m_hstart;
  int       m_t;

  function automatic logic [7:0] dut_outs();
    return {bus.o_sec_up, bus.o_sec_down, bus.o_min_up, bus.o_min_down,
            bus.o_hour_up, bus.o_hour_down, bus.o_mode};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_deb[b]  = 0;
      m_debp[b] = 0;
      m_run[b]  = 0;
    end
    m_mode   = 0;
    m_out    = '0;
    m_hact   = 0;
    m_hdir   = 0;
    m_hstart = 0;
    m_t      = 0;
  endtask

  // one clock edge of the spec's behaviour, from the inputs of the cycle
  task automatic model_step();
    bit       raw [3];
    bit       p   [3];
    bit       fu, fd;
    bit [5:0] o;
    int       old, n;
    raw[0] = bus.i_btn_up;
    raw[1] = bus.i_btn_down;
    raw[2] = bus.i_btn_mode;
    for (int b = 0; b < 3; b++) p[b] = m_deb[b] && !m_debp[b];
    fu  = 0;
    fd  = 0;
    o   = '0;
    old = m_mode;
    if (old == 0 && bus.i_tick) o[5] = 1;
    if (p[2]) begin
      m_mode = (m_mode + 1) % 4;
      m_hact = 0;
    end else if (old != 0) begin
      if ((p[0] && p[1]) || (p[0] && m_deb[1]) || (p[1] && m_deb[0])) begin
        fu = 1;
        fd = 1;
        m_hact = 0;
      end else if (p[0] || p[1]) begin
        fu = p[0];
        fd = p[1];
        m_hact = 1;
        m_hdir = p[0] ? 0 : 1;
        m_hstart = m_t + 1;
      end else if (m_hact) begin
        if (!m_deb[m_hdir]) begin
          m_hact = 0;
        end else begin
          n = m_t + 1 - m_hstart;
          if (n >= HOLD && (n - HOLD) % REP == 0) begin
            if (m_hdir == 0) fu = 1;
            else fd = 1;
          end
        end
      end
    end
    if (old == 1) o[1:0] = {fu, fd};
    if (old == 2) o[3:2] = {fu, fd};
    if (old == 3) o[5:4] = {fu, fd};
    for (int b = 0; b < 3; b++) begin
      m_debp[b] = m_deb[b];
      if (raw[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_deb[b] = raw[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_out = o;
    m_t++;
  endtask

  task automatic cyc(input string name);
    @(posedge i_clk);
    model_step();
    #1;
    check(name, dut_outs(), {m_out, m_mode[1:0]});
  endtask

  task automatic press_mode();
    bus.i_btn_mode = 1;
    repeat (5) cyc("model_mode");
    bus.i_btn_mode = 0;
    repeat (5) cyc("model_mode");
  endtask

  int   first;
  int   offs [$];
  int   exp_offs [5] = '{0, 10, 13, 16, 19};
  int   n_up, n_dn, n_both, n_any;

  initial begin
    bus.i_tick     = 0;
    bus.i_btn_up   = 0;
    bus.i_btn_down = 0;
    bus.i_btn_mode = 0;

    for (int i = 0; i < 30; i++) tbl[i] = '0;
    tbl[0].tick = 1; tbl[0].pulses = 6'b100000;
    tbl[2].tick = 1; tbl[2].pulses = 6'b100000;
    tbl[4].tick = 1; tbl[4].pulses = 6'b100000;
    for (int i = 6; i <= 10; i++) tbl[i].md = 1;
    for (int i = 10; i < 30; i++) tbl[i].mode = 2'd1;
    tbl[15].up = 1; tbl[16].up = 1; tbl[18].up = 1;
    for (int i = 20; i <= 23; i++) tbl[i].up = 1;
    tbl[24].pulses = 6'b000010;

    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_outs", 32'(dut_outs()), 0);
    @(negedge i_clk);
    i_rstn = 1;

    // ticks in RUN, step to SET_HOUR, bouncing UP
    for (int i = 0; i < 30; i++) begin
      bus.i_tick     = tbl[i].tick;
      bus.i_btn_up   = tbl[i].up;
      bus.i_btn_down = tbl[i].dn;
      bus.i_btn_mode = tbl[i].md;
      cyc("model_tbl");
      check($sformatf("tbl[%0d]", i), 32'(dut_outs()),
            32'({tbl[i].pulses, tbl[i].mode}));
    end

    // UP held in SET_HOUR: auto-repeat timing
    first = -1;
    bus.i_btn_up = 1;
    for (int i = 0; i < 40; i++) begin
      cyc("model_hold");
      if (bus.o_hour_up) begin
        if (first < 0) first = i;
        offs.push_back(i - first);
      end
      if (first >= 0 && i - first == 17) bus.i_btn_up = 0;
    end
    check("hold_pulse_count", offs.size(), 5);
    for (int k = 0; k < 5 && k < offs.size(); k++)
      check($sformatf("hold_offset[%0d]", k), offs[k], exp_offs[k]);

    // SET_MIN: simultaneous UP+DOWN is one clear, no repeat
    press_mode();
    check("mode_set_min", bus.o_mode, 2);
    n_up = 0; n_dn = 0; n_both = 0;
    bus.i_btn_up   = 1;
    bus.i_btn_down = 1;
    for (int i = 0; i < 25; i++) begin
      cyc("model_clear");
      n_up   += int'(bus.o_min_up);
      n_dn   += int'(bus.o_min_down);
      n_both += int'(bus.o_min_up & bus.o_min_down);
    end
    check("clear_up_count", n_up, 1);
    check("clear_dn_count", n_dn, 1);
    check("clear_both_count", n_both, 1);
    bus.i_btn_up   = 0;
    bus.i_btn_down = 0;
    repeat (6) cyc("model_idle");

    // SET_SEC freezes ticks; tick with leaving MODE press is dropped
    press_mode();
    check("mode_set_sec", bus.o_mode, 3);
    bus.i_tick = 1;
    cyc("model_frozen");
    check("frozen_tick", bus.o_sec_up, 0);
    bus.i_tick = 0;
    repeat (3) cyc("model_idle");
    bus.i_btn_mode = 1;
    repeat (4) cyc("model_mode");
    bus.i_tick = 1;
    cyc("model_mode_tick");
    check("exit_mode", bus.o_mode, 0);
    check("exit_tick_dropped", bus.o_sec_up, 0);
    bus.i_btn_mode = 0;
    cyc("model_run_tick");
    check("run_tick", bus.o_sec_up, 1);
    bus.i_tick = 0;
    repeat (6) cyc("model_idle");

    // reset in the middle of a repeat in SET_MIN
    press_mode();
    press_mode();
    check("mode_set_min2", bus.o_mode, 2);
    first = -1;
    bus.i_btn_up = 1;
    for (int i = 0; i < 30; i++) begin
      cyc("model_prerst");
      if (bus.o_min_up && first < 0) first = i;
      if (first >= 0 && i - first == 15) break;
    end
    check("prerst_pulse_seen", 32'(first >= 0), 1);
    #2;
    i_rstn = 0;
    #1;
    check("async_reset_outs", 32'(dut_outs()), 0);
    repeat (2) @(posedge i_clk);
    #1;
    check("held_reset_outs", 32'(dut_outs()), 0);
    model_reset();
    @(negedge i_clk);
    i_rstn = 1;
    n_any = 0;
    for (int i = 0; i < 20; i++) begin
      cyc("model_postrst");
      n_any += int'(|dut_outs());
    end
    check("postrst_no_pulse", n_any, 0);
    bus.i_btn_up = 0;

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      bus.i_tick = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) bus.i_btn_up = ~bus.i_btn_up;
      if ($urandom_range(0, 19) == 0) bus.i_btn_down = ~bus.i_btn_down;
      if ($urandom_range(0, 39) == 0) bus.i_btn_mode = ~bus.i_btn_mode;
      cyc("model_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
